// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors, receiver FSM states and the
// baud divider helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Rounded clocks-per-tick: round(clk_freq / (baud * os)).
  function automatic int calc_div(input longint clk_freq, input longint baud, input longint os);
    longint den;
    den = baud * os;
    return int'((clk_freq + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks, with a
// restart input that realigns the phase to an external event.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CW'(DIV - 1)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = (cnt_reg == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, oversampled 2-of-3 majority
// sampling, configurable data/parity/stop format, parity and framing errors.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = calc_div(longint'(CLK_FREQ), longint'(BAUD), longint'(OVERSAMPLE));
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_param: clock divider must be 2 or greater");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_rx_param: OVERSAMPLE must be even and at least 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
      (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_fmt
    $error("uart_rx_param: unsupported frame format");
  end

  rx_state_t state_reg, state_next;

  logic [1:0]           sync_reg;
  logic                 rx_prev_reg;
  logic [SW-1:0]        s_cnt_reg;
  logic [1:0]           samp_reg;
  logic [BW-1:0]        bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic                 stop_err_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_reg;

  logic rx_s, start_edge, tick, restart, eval, wrap, maj, frame_bad, par_bad, finish;
  logic last_stop;

  assign rx_s       = sync_reg[1];
  assign start_edge = rx_prev_reg & ~rx_s;
  assign eval       = tick && (s_cnt_reg == SW'(M + 1));
  assign wrap       = tick && (s_cnt_reg == SW'(OVERSAMPLE - 1));
  assign maj        = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
  assign last_stop  = 1'(STOP_BITS - 1);
  assign frame_bad  = stop_err_reg | ~maj;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    par_bad = 1'b0;
    if (PARITY == PARITY_ODD) begin
      par_bad = ~(^shift_reg ^ par_reg);
    end else if (PARITY == PARITY_EVEN) begin
      par_bad = ^shift_reg ^ par_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start_edge) state_next = START;
      START: begin
        if (eval && maj) state_next = IDLE;
        else if (wrap)   state_next = DATA;
      end
      DATA: begin
        if (wrap && (bit_cnt_reg == BW'(DATA_BITS - 1))) begin
          state_next = (PARITY != PARITY_NONE) ? PAR : STOP;
        end
      end
      PAR:       if (wrap) state_next = STOP;
      STOP: begin
        if (eval && (stop_cnt_reg == last_stop)) begin
          state_next = frame_bad ? WAIT_IDLE : IDLE;
        end
      end
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg != IDLE);
    restart = (state_reg == IDLE) && start_edge;
    finish  = (state_reg == STOP) && eval && (stop_cnt_reg == last_stop);
  end

  // Bit-phase counter is held at zero while idle so each start edge begins a fresh bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg     <= 2'b11;
      rx_prev_reg  <= 1'b1;
      s_cnt_reg    <= '0;
      samp_reg     <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      stop_err_reg <= 1'b0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      rx_prev_reg <= rx_s;
      if (restart || (state_reg == IDLE)) begin
        s_cnt_reg <= '0;
      end else if (tick) begin
        s_cnt_reg <= (s_cnt_reg == SW'(OVERSAMPLE - 1)) ? '0 : s_cnt_reg + SW'(1);
      end
      if (tick && (s_cnt_reg == SW'(M - 1))) samp_reg[0] <= rx_s;
      if (tick && (s_cnt_reg == SW'(M)))     samp_reg[1] <= rx_s;
      if (state_reg == START) begin
        bit_cnt_reg  <= '0;
        stop_cnt_reg <= 1'b0;
        stop_err_reg <= 1'b0;
      end
      if ((state_reg == DATA) && eval) shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
      if ((state_reg == DATA) && wrap) bit_cnt_reg <= bit_cnt_reg + BW'(1);
      if ((state_reg == PAR) && eval)  par_reg <= maj;
      if ((state_reg == STOP) && eval) stop_err_reg <= stop_err_reg | ~maj;
      if ((state_reg == STOP) && wrap) stop_cnt_reg <= stop_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid   <= finish;
      parity_err <= finish & par_bad;
      frame_err  <= finish & frame_bad;
      if (finish) rx_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receiver configurations (8N1, 8E1, 8N2)
// driven with directed vectors, corner-case sequences and random frames.
module tb_uart_rx_param;

  localparam int CLKF  = 1_600_000;
  localparam int BAUDR = 10_000;
  localparam int OS    = 16;
  localparam int BIT   = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] vld, perr, ferr, bsy;
  logic [7:0] data [3];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .OVERSAMPLE(OS)) dut0 (
    .clk(clk), .rst(rst), .rx(rx_line[0]), .rx_data(data[0]), .rx_valid(vld[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .busy(bsy[0]));

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .OVERSAMPLE(OS), .PARITY(2)) dut1 (
    .clk(clk), .rst(rst), .rx(rx_line[1]), .rx_data(data[1]), .rx_valid(vld[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .busy(bsy[1]));

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .OVERSAMPLE(OS), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .rx(rx_line[2]), .rx_data(data[2]), .rx_valid(vld[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .busy(bsy[2]));

  function automatic int par_mode(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int n_stop(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t;
  } rec_t;

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       pbit;
    logic       stop_low;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_busy_after;
  } vec_t;

  rec_t       mon_q [$];
  logic [2:0] vld_d = 3'b000;
  logic [2:0] busy_after = 3'b000;
  int         quiet_viol = 0;

  // Capture every completed frame and the busy level one cycle after its pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld_d[i]) busy_after[i] = bsy[i];
      if (vld[i]) begin
        rec_t r;
        r.idx = i;
        r.d   = data[i];
        r.pe  = perr[i];
        r.fe  = ferr[i];
        r.t   = cyc;
        mon_q.push_back(r);
      end else if (perr[i] || ferr[i]) begin
        quiet_viol++;
      end
    end
    vld_d = vld;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int i, input logic v, input int n);
    rx_line[i] = v;
    repeat (n) @(negedge clk);
  endtask

  // glitch_bit selects a data bit that gets a 10-clk inverted pulse near its centre (-1: none).
  task automatic send_frame(input int i, input logic [7:0] d, input logic pbit,
                            input logic stop_low, input int gap, input int glitch_bit);
    hold(i, 1'b0, BIT);
    for (int k = 0; k < 8; k++) begin
      if (k == glitch_bit) begin
        hold(i, d[k], 80);
        hold(i, ~d[k], 10);
        hold(i, d[k], 70);
      end else begin
        hold(i, d[k], BIT);
      end
    end
    if (par_mode(i) != 0) hold(i, pbit, BIT);
    for (int s = 0; s < n_stop(i); s++) hold(i, (s == 0) ? ~stop_low : 1'b1, BIT);
    hold(i, 1'b1, gap);
  endtask

  task automatic wait_frames(input int n);
    int waited = 0;
    while ((mon_q.size() < n) && (waited < 400)) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic expect_frame(input string name, input int i, input logic [7:0] d,
                              input logic pe, input logic fe);
    rec_t r;
    wait_frames(1);
    check({name, " present"}, int'(mon_q.size() > 0), 1);
    if (mon_q.size() > 0) begin
      r = mon_q.pop_front();
      check({name, " dut"}, r.idx, i);
      check({name, " data"}, int'(r.d), int'(d));
      check({name, " parity_err"}, int'(r.pe), int'(pe));
      check({name, " frame_err"}, int'(r.fe), int'(fe));
      $display("frame %s: dut%0d data=%02h perr=%0b ferr=%0b (want %02h %0b %0b)",
               name, r.idx, r.d, r.pe, r.fe, d, pe, fe);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    rec_t b2b [3];
    logic [7:0] rd;
    logic       rp, rs, exp_pe;
    int         ri, rgap;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h03, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1, 8'h03, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1, 8'hF1, 1'b0, 1'b0, 8'hF1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{2, 8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{2, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    check("reset rx_valid", int'(vld), 0);
    check("reset busy", int'(bsy), 0);
    check("reset parity_err", int'(perr), 0);
    check("reset frame_err", int'(ferr), 0);
    check("reset rx_data", int'({data[0], data[1], data[2]}), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].idx, vecs[v].d, vecs[v].pbit, vecs[v].stop_low, 200, -1);
      expect_frame($sformatf("vec%0d", v), vecs[v].idx, vecs[v].exp_d, vecs[v].exp_pe, vecs[v].exp_fe);
      check($sformatf("vec%0d busy_after", v), int'(busy_after[vecs[v].idx]), int'(vecs[v].exp_busy_after));
    end

    // Line held low for 20 bit periods: a single all-zero framing-error frame.
    hold(0, 1'b0, 20 * BIT);
    hold(0, 1'b1, 400);
    expect_frame("break", 0, 8'h00, 1'b0, 1'b1);
    repeat (400) @(negedge clk);
    check("break single frame", mon_q.size(), 0);

    // Short low glitch on the idle line is a false start.
    hold(0, 1'b0, 40);
    check("glitch busy set", int'(bsy[0]), 1);
    hold(0, 1'b1, 300);
    check("glitch busy clear", int'(bsy[0]), 0);
    check("glitch no frame", mon_q.size(), 0);

    send_frame(0, 8'hFF, 1'b0, 1'b0, 200, 3);
    expect_frame("vote FF", 0, 8'hFF, 1'b0, 1'b0);

    // Back-to-back 8N2 frames with no idle gap.
    send_frame(2, 8'h00, 1'b0, 1'b0, 0, -1);
    send_frame(2, 8'hFF, 1'b0, 1'b0, 0, -1);
    send_frame(2, 8'h55, 1'b0, 1'b0, 200, -1);
    wait_frames(3);
    check("b2b count", mon_q.size(), 3);
    if (mon_q.size() == 3) begin
      for (int k = 0; k < 3; k++) b2b[k] = mon_q.pop_front();
      check("b2b data0", int'(b2b[0].d), 8'h00);
      check("b2b data1", int'(b2b[1].d), 8'hFF);
      check("b2b data2", int'(b2b[2].d), 8'h55);
      check("b2b spacing01", b2b[1].t - b2b[0].t, 11 * BIT);
      check("b2b spacing12", b2b[2].t - b2b[1].t, 11 * BIT);
      $display("b2b frames: %02h %02h %02h at cycles %0d %0d %0d",
               b2b[0].d, b2b[1].d, b2b[2].d, b2b[0].t, b2b[1].t, b2b[2].t);
    end
    mon_q.delete();

    // Reset in the middle of the data field aborts the frame.
    hold(0, 1'b0, BIT);
    hold(0, 1'b1, BIT);
    hold(0, 1'b0, BIT);
    hold(0, 1'b1, 80);
    check("pre-reset busy", int'(bsy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset rx_data", int'(data[0]), 0);
    check("mid reset busy", int'(bsy[0]), 0);
    check("mid reset valid", int'(vld[0]), 0);
    rst = 1'b0;
    hold(0, 1'b1, 1200);
    check("mid reset no frame", mon_q.size(), 0);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 200, -1);
    expect_frame("after reset", 0, 8'hC3, 1'b0, 1'b0);

    // Random frames checked against the frame-format rules.
    for (int n = 0; n < 12; n++) begin
      ri   = n % 3;
      rd   = 8'($urandom_range(0, 255));
      rp   = 1'($urandom_range(0, 1));
      rs   = ($urandom_range(0, 4) == 0);
      rgap = rs ? 200 + $urandom_range(0, 100) : $urandom_range(0, 160);
      if (par_mode(ri) == 0) exp_pe = 1'b0;
      else exp_pe = ((($countones(rd) + int'(rp)) % 2) != ((par_mode(ri) == 1) ? 1 : 0));
      send_frame(ri, rd, rp, rs, rgap, -1);
      expect_frame($sformatf("rand%0d", n), ri, rd, exp_pe, rs);
    end

    repeat (50) @(negedge clk);
    check("flags quiet without rx_valid", quiet_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
